dvi_tx_timing_ctl: RTL

//  Video timing sequencer that drives the dvi_tx encoder/serdes input: produces hsync/vsync/de and fetches 24b pixels

---
 rtl/dvi_tx_timing_ctl.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/dvi_tx_timing_ctl.sv
// dvi_tx_timing_ctl: pixel-clock timing sequencer in front of dvi_tx.
// Generates hsync/vsync/de from free-running h/v counters and pulls 24b pixels
// from a valid/ready stream during the active region. Frame alignment is
// checked against s_user at pixel (0,0); a misaligned frame forces a resync.
// Optional colour-bar test pattern: define DVI_TX_CTL_TPG_EN (adds tpg_sel).
module dvi_tx_timing_ctl #(
    parameter int   H_ACTIVE  = 640,
    parameter int   H_FP      = 16,
    parameter int   H_SYNC    = 96,
    parameter int   H_BP      = 48,
    parameter int   V_ACTIVE  = 480,
    parameter int   V_FP      = 10,
    parameter int   V_SYNC    = 2,
    parameter int   V_BP      = 33,
    parameter logic HSYNC_POL = 1'b0,
    parameter logic VSYNC_POL = 1'b0,
    parameter int   H_WIDTH   = 12,
    parameter int   V_WIDTH   = 11
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [23:0] s_data,
    input  logic        s_user,
    input  logic        s_valid,
`ifdef DVI_TX_CTL_TPG_EN
    input  logic        tpg_sel,
`endif
    output logic        s_ready,
    output logic        out_vsync,
    output logic        out_hsync,
    output logic        out_de,
    output logic [23:0] out_data,
    output logic [3:0]  out_ctl,
    output logic        busy,
    output logic        frame_start,
    output logic        underflow
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [H_WIDTH-1:0] H_LAST   = H_WIDTH'(H_TOTAL - 1);
    localparam logic [H_WIDTH-1:0] H_ACT    = H_WIDTH'(H_ACTIVE);
    localparam logic [H_WIDTH-1:0] HS_START = H_WIDTH'(H_ACTIVE + H_FP);
    localparam logic [H_WIDTH-1:0] HS_END   = H_WIDTH'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [V_WIDTH-1:0] V_LAST   = V_WIDTH'(V_TOTAL - 1);
    localparam logic [V_WIDTH-1:0] V_ACT    = V_WIDTH'(V_ACTIVE);
    localparam logic [V_WIDTH-1:0] VS_START = V_WIDTH'(V_ACTIVE + V_FP);
    localparam logic [V_WIDTH-1:0] VS_END   = V_WIDTH'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic [1:0] {IDLE = 2'd0, RESYNC = 2'd1, RUN = 2'd2} state_t;

    state_t             state, state_nxt;
    logic [H_WIDTH-1:0] h;
    logic [V_WIDTH-1:0] v;
    logic               h_last, frame_end, active, at_origin;
    logic               hs_act, vs_act;
    logic               misalign_q, misalign_now;
    logic               tpg_mode, run_eff;
    logic [23:0]        pix;

    assign h_last    = (h == H_LAST);
    assign frame_end = h_last && (v == V_LAST);
    assign active    = (h < H_ACT) && (v < V_ACT);
    assign at_origin = (h == '0) && (v == '0);
    assign hs_act    = (h >= HS_START) && (h < HS_END);
    assign vs_act    = (v >= VS_START) && (v < VS_END);

    // Test pattern overrides the stream and behaves like RUN in any busy state
    assign run_eff   = (state == RUN) || (tpg_mode && state != IDLE);

    // An accepted pixel whose s_user disagrees with the (0,0) position means
    // the stream and the raster have drifted apart.
    assign misalign_now = (state == RUN) && !tpg_mode && active && s_valid &&
                          (s_user != at_origin);

    assign busy    = (state != IDLE);
    assign out_ctl = 4'b0000;

`ifdef DVI_TX_CTL_TPG_EN
    localparam logic [H_WIDTH+2:0] H_ACT_X = (H_WIDTH+3)'(H_ACTIVE);
    logic [2:0] bar;
    assign bar = 3'({h, 3'b000} / H_ACT_X);

    // Pattern selection is latched only between frames so a frame is never split
    always_ff @(posedge clk) begin
        if (reset)
            tpg_mode <= 1'b0;
        else if (state == IDLE || frame_end)
            tpg_mode <= tpg_sel;
    end
`else
    assign tpg_mode = 1'b0;
`endif

    // Pixel source for the active region: stream (zero on underflow) or bars
    always_comb begin
        pix = s_valid ? s_data : 24'h000000;
`ifdef DVI_TX_CTL_TPG_EN
        if (tpg_mode)
            pix = {{8{bar[2]}}, {8{bar[1]}}, {8{bar[0]}}};
`endif
    end

    // Handshake: RESYNC drains the stream but holds a start-of-frame pixel at
    // the head so it is still present when the frame boundary is reached.
    always_comb begin
        s_ready = 1'b0;
        if (!reset && !tpg_mode) begin
            case (state)
                RESYNC:  s_ready = !(s_valid && s_user);
                RUN:     s_ready = active;
                default: s_ready = 1'b0;
            endcase
        end
    end

    // State decisions only happen at the last cycle of a frame (or leaving IDLE)
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (enable) state_nxt = RESYNC;
            default: begin
                if (frame_end) begin
                    if (!enable)
                        state_nxt = IDLE;
                    else if (tpg_mode)
                        state_nxt = RESYNC;  // realign the stream once the pattern ends
                    else if (state == RESYNC)
                        state_nxt = (s_valid && s_user) ? RUN : RESYNC;
                    else
                        state_nxt = (misalign_q || misalign_now) ? RESYNC : RUN;
                end
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Raster counters, parked at (0,0) while idle
    always_ff @(posedge clk) begin
        if (reset || state == IDLE) begin
            h <= '0;
            v <= '0;
        end else if (h_last) begin
            h <= '0;
            v <= (v == V_LAST) ? '0 : v + 1'b1;
        end else begin
            h <= h + 1'b1;
        end
    end

    // Remember a misaligned pixel until the frame boundary decides the next state
    always_ff @(posedge clk) begin
        if (reset || state == IDLE || frame_end)
            misalign_q <= 1'b0;
        else if (misalign_now)
            misalign_q <= 1'b1;
    end

    // Registered video outputs, one clock behind the counters
    always_ff @(posedge clk) begin
        if (reset) begin
            out_hsync   <= ~HSYNC_POL;
            out_vsync   <= ~VSYNC_POL;
            out_de      <= 1'b0;
            out_data    <= 24'h000000;
            frame_start <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            out_hsync   <= (busy && hs_act) ? HSYNC_POL : ~HSYNC_POL;
            out_vsync   <= (busy && vs_act) ? VSYNC_POL : ~VSYNC_POL;
            out_de      <= run_eff && active;
            out_data    <= (run_eff && active) ? pix : 24'h000000;
            frame_start <= run_eff && active && at_origin;
            underflow   <= (state == RUN) && !tpg_mode && active && !s_valid;
        end
    end

endmodule
